fwd_select_unit: RTL and testbench



---
 rtl/fwd_select_unit.sv | 144 ++++++++++++++
 tb/tb_fwd_select_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_select_unit.sv
// Forwarding select and load-use stall control for the 5-stage pipeline (EX/MEM/WB shadow slots).
// Optional: define FWD_RET_STAGE_EN to add the retired-result path (select 11) for non-write-through register files.
module fwd_select_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  flush,
  output logic                  stall_out,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  ex_valid
);

  localparam int NUM_SRC = 2;

  logic                  ex_valid_reg;
  logic [REG_ADDR_W-1:0] ex_rd_reg;
  logic                  ex_regwrite_reg;
  logic                  ex_memread_reg;
  logic                  mem_write_reg;
  logic [REG_ADDR_W-1:0] mem_rd_reg;
`ifdef FWD_RET_STAGE_EN
  // The RET slot is only ever compared as its pre-shift image, which is the WB slot.
  logic                  wb_write_reg;
  logic [REG_ADDR_W-1:0] wb_rd_reg;
  logic [NUM_REGS-1:0]   wb_write_mask;
  logic [NUM_SRC-1:0]    wb_hit;
`endif

  logic                  ex_writing;
  logic [NUM_REGS-1:0]   ex_write_mask;
  logic [NUM_REGS-1:0]   ex_load_mask;
  logic [NUM_REGS-1:0]   mem_write_mask;

  logic [NUM_SRC-1:0][REG_ADDR_W-1:0] src_rs;
  logic [NUM_SRC-1:0]                 src_uses;
  logic [NUM_SRC-1:0]                 src_load_hit;
  logic [NUM_SRC-1:0]                 ex_hit;
  logic [NUM_SRC-1:0]                 mem_hit;
  logic [NUM_SRC-1:0][1:0]            sel_next;
  logic [NUM_SRC-1:0][1:0]            sel_reg;
  logic                               hazard;

  assign ex_writing = ex_valid_reg && ex_regwrite_reg && (ex_rd_reg != '0);

  // One-hot "pending write" decode per slot; x0 never produces a hit.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg_decode
      if (gi == 0) begin : g_zero
        assign ex_write_mask[gi]  = 1'b0;
        assign ex_load_mask[gi]   = 1'b0;
        assign mem_write_mask[gi] = 1'b0;
`ifdef FWD_RET_STAGE_EN
        assign wb_write_mask[gi]  = 1'b0;
`endif
      end else begin : g_nonzero
        assign ex_write_mask[gi]  = ex_writing && (ex_rd_reg == REG_ADDR_W'(gi));
        assign ex_load_mask[gi]   = ex_write_mask[gi] && ex_memread_reg;
        assign mem_write_mask[gi] = mem_write_reg && (mem_rd_reg == REG_ADDR_W'(gi));
`ifdef FWD_RET_STAGE_EN
        assign wb_write_mask[gi]  = wb_write_reg && (wb_rd_reg == REG_ADDR_W'(gi));
`endif
      end
    end
  endgenerate

  assign src_rs[0]   = id_rs1;
  assign src_rs[1]   = id_rs2;
  assign src_uses[0] = id_uses_rs1;
  assign src_uses[1] = id_uses_rs2;

  // Per-operand priority: youngest producer wins.
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign src_load_hit[gi] = src_uses[gi] && ex_load_mask[src_rs[gi]];
      assign ex_hit[gi]       = src_uses[gi] && (src_rs[gi] != '0) && ex_write_mask[src_rs[gi]];
      assign mem_hit[gi]      = src_uses[gi] && (src_rs[gi] != '0) && mem_write_mask[src_rs[gi]];
`ifdef FWD_RET_STAGE_EN
      assign wb_hit[gi]       = src_uses[gi] && (src_rs[gi] != '0) && wb_write_mask[src_rs[gi]];
      assign sel_next[gi]     = ex_hit[gi]  ? 2'b10 :
                                mem_hit[gi] ? 2'b01 :
                                wb_hit[gi]  ? 2'b11 : 2'b00;
`else
      assign sel_next[gi]     = ex_hit[gi]  ? 2'b10 :
                                mem_hit[gi] ? 2'b01 : 2'b00;
`endif
    end
  endgenerate

  assign hazard    = id_valid && (|src_load_hit);
  assign stall_out = hazard && !flush && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_reg    <= 1'b0;
      ex_rd_reg       <= '0;
      ex_regwrite_reg <= 1'b0;
      ex_memread_reg  <= 1'b0;
      mem_write_reg   <= 1'b0;
      mem_rd_reg      <= '0;
`ifdef FWD_RET_STAGE_EN
      wb_write_reg    <= 1'b0;
      wb_rd_reg       <= '0;
`endif
      sel_reg         <= '0;
    end else begin
      mem_write_reg <= ex_writing;
      mem_rd_reg    <= ex_rd_reg;
`ifdef FWD_RET_STAGE_EN
      wb_write_reg  <= mem_write_reg;
      wb_rd_reg     <= mem_rd_reg;
`endif
      if (flush || stall_out) begin
        ex_valid_reg    <= 1'b0;
        ex_rd_reg       <= '0;
        ex_regwrite_reg <= 1'b0;
        ex_memread_reg  <= 1'b0;
        sel_reg         <= '0;
      end else begin
        ex_valid_reg    <= id_valid;
        ex_rd_reg       <= id_rd;
        ex_regwrite_reg <= id_regwrite;
        ex_memread_reg  <= id_memread;
        sel_reg         <= sel_next;
      end
    end
  end

  assign fwd_a_sel = sel_reg[0];
  assign fwd_b_sel = sel_reg[1];
  assign ex_valid  = ex_valid_reg;

endmodule

// File: tb/tb_fwd_select_unit.sv
// Self-checking bench for fwd_select_unit: directed pipeline scenarios plus a randomized phase against a slot-history model.
module tb_fwd_select_unit;

  logic       clk;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_memread;
  logic       flush;
  logic       stall_out;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic       ex_valid;

  fwd_select_unit #(.REG_ADDR_W(5), .NUM_REGS(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .flush       (flush),
    .stall_out   (stall_out),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
    .ex_valid    (ex_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } slot_t;

  typedef struct packed {
    logic       v;
    logic [1:0] a;
    logic [1:0] b;
  } exp_t;

  slot_t hist [3];   // 0 = EX, 1 = MEM, 2 = WB
  exp_t  sb_q [$];
  int    tests_run;
  int    tests_failed;
  int    cyc;
  logic  st;

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s got=%b exp=%b (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic writes(input slot_t s);
    return s.v && s.rw && (s.rd != 5'd0);
  endfunction

  function automatic logic [1:0] model_sel(input logic u, input logic [4:0] rs);
    if (!u || rs == 5'd0) return 2'b00;
    if (writes(hist[0]) && hist[0].rd == rs) return 2'b10;
    if (writes(hist[1]) && hist[1].rd == rs) return 2'b01;
`ifdef FWD_RET_STAGE_EN
    if (writes(hist[2]) && hist[2].rd == rs) return 2'b11;
`endif
    return 2'b00;
  endfunction

  // One clock of stimulus: check the combinational stall, queue the expected EX view, compare after the edge.
  task automatic drive(input logic rst, input logic fl, input logic v,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic rw, input logic mr,
                       output logic stl);
    exp_t e;
    logic haz;
    logic exp_stl;
    @(negedge clk);
    reset = rst; flush = fl; id_valid = v; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_regwrite = rw; id_memread = mr;
    #1;
    stl = stall_out;
    haz = v && writes(hist[0]) && hist[0].mr &&
          ((u1 && rs1 == hist[0].rd) || (u2 && rs2 == hist[0].rd));
    exp_stl = haz && !fl && !rst;
    check("stall", {1'b0, stall_out}, {1'b0, exp_stl});
    if (rst || fl || exp_stl) e = '0;
    else begin
      e.v = v;
      e.a = model_sel(u1, rs1);
      e.b = model_sel(u2, rs2);
    end
    sb_q.push_back(e);
    @(posedge clk);
    if (rst) begin
      foreach (hist[i]) hist[i] = '0;
    end else begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      if (fl || exp_stl) hist[0] = '0;
      else begin
        hist[0].v = v; hist[0].rd = rd; hist[0].rw = rw; hist[0].mr = mr;
      end
    end
    #1;
    cyc++;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("ex_valid", {1'b0, ex_valid}, {1'b0, e.v});
      check("sel_a", fwd_a_sel, e.a);
      check("sel_b", fwd_b_sel, e.b);
    end
    $display("[TB] cyc %0d rst=%b fl=%b v=%b rd=%0d rs1=%0d rs2=%0d stall=%b -> ex_valid=%b a=%b b=%b",
             cyc, rst, fl, v, rd, rs1, rs2, stl, ex_valid, fwd_a_sel, fwd_b_sel);
  endtask

  task automatic alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2, output logic stl);
    drive(1'b0, 1'b0, 1'b1, rd, rs1, rs2, 1'b1, 1'b1, 1'b1, 1'b0, stl);
  endtask

  task automatic ld(input logic [4:0] rd, input logic [4:0] rs1, output logic stl);
    drive(1'b0, 1'b0, 1'b1, rd, rs1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, stl);
  endtask

  task automatic nop(output logic stl);
    drive(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, stl);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run = 0; tests_failed = 0; cyc = 0;
    foreach (hist[i]) hist[i] = '0;
    reset = 1'b1; flush = 1'b0; id_valid = 1'b0; id_rd = '0; id_rs1 = '0; id_rs2 = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_regwrite = 1'b0; id_memread = 1'b0;

    // Reset held two cycles with a valid load in ID
    repeat (2) begin
      drive(1'b1, 1'b0, 1'b1, 5'd3, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, st);
      check("rst_stall", {1'b0, st}, 2'b00);
      check("rst_exv", {1'b0, ex_valid}, 2'b00);
      check("rst_a", fwd_a_sel, 2'b00);
      check("rst_b", fwd_b_sel, 2'b00);
    end

    // Back-to-back dependency
    alu(5'd5, 5'd1, 5'd2, st);
    alu(5'd6, 5'd5, 5'd7, st);
    check("b2b_a", fwd_a_sel, 2'b10);
    check("b2b_b", fwd_b_sel, 2'b00);

    // Distance-2 dependency, then the same through x0
    alu(5'd5, 5'd1, 5'd2, st);
    nop(st);
    alu(5'd8, 5'd1, 5'd5, st);
    check("d2_b", fwd_b_sel, 2'b01);
    alu(5'd0, 5'd1, 5'd2, st);
    nop(st);
    alu(5'd8, 5'd1, 5'd0, st);
    check("d2_x0_b", fwd_b_sel, 2'b00);

    // Load-use: one stall, bubble, then both operands from WB-bound MEM
    ld(5'd3, 5'd1, st);
    alu(5'd4, 5'd3, 5'd3, st);
    check("lu_stall", {1'b0, st}, 2'b01);
    check("lu_bubble", {1'b0, ex_valid}, 2'b00);
    alu(5'd4, 5'd3, 5'd3, st);
    check("lu_once", {1'b0, st}, 2'b00);
    check("lu_exv", {1'b0, ex_valid}, 2'b01);
    check("lu_a", fwd_a_sel, 2'b01);
    check("lu_b", fwd_b_sel, 2'b01);

    // Flush in the hazard cycle wins over the stall
    ld(5'd3, 5'd1, st);
    drive(1'b0, 1'b1, 1'b1, 5'd4, 5'd3, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, st);
    check("fl_stall", {1'b0, st}, 2'b00);
    check("fl_exv", {1'b0, ex_valid}, 2'b00);
    check("fl_a", fwd_a_sel, 2'b00);
    check("fl_b", fwd_b_sel, 2'b00);

    // Invalid ID instruction: selects still computed, EX marked bubble
    alu(5'd5, 5'd1, 5'd2, st);
    drive(1'b0, 1'b0, 1'b0, 5'd6, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, st);
    check("inv_exv", {1'b0, ex_valid}, 2'b00);
    check("inv_a", fwd_a_sel, 2'b10);

    // Retired-result distance
    alu(5'd9, 5'd1, 5'd2, st);
    nop(st);
    nop(st);
    alu(5'd10, 5'd9, 5'd1, st);
`ifdef FWD_RET_STAGE_EN
    check("ret_a", fwd_a_sel, 2'b11);
`else
    check("ret_a", fwd_a_sel, 2'b00);
`endif

    // Mid-operation reset discards an in-flight load and masks the stall
    ld(5'd3, 5'd1, st);
    drive(1'b1, 1'b0, 1'b1, 5'd4, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, st);
    check("mrst_stall", {1'b0, st}, 2'b00);
    check("mrst_exv", {1'b0, ex_valid}, 2'b00);
    alu(5'd5, 5'd3, 5'd0, st);
    check("mrst_disc", fwd_a_sel, 2'b00);

    // Randomized traffic over a small register window to provoke hits
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) != 0,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, st);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
